// File: rtl/dmem_responder.sv
// Handshaked word-wide data-memory responder: one outstanding load/store, response
// presented after LATENCY cycles and held until the initiator takes it.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        busy_o
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] ByteLimit = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  CntInit   = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic          accept;
  logic          acc_err;
  logic [31:0]   acc_data;
  logic          resp_load;

  logic [31:0] pend_data_q, rdata_q;
  logic        pend_err_q, err_q;

  always_comb begin
    idx      = req_addr_i[AW+1:2];
    accept   = (state_q == StIdle) && req_valid_i;
    acc_err  = (req_addr_i[1:0] != 2'b00) || (req_addr_i >= ByteLimit);
    acc_data = (req_write_i || acc_err) ? 32'd0 : mem[idx];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          if (LATENCY == 1) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = CntInit;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) state_d = StResp;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StResp: begin
        if (resp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output registers only move on RESP entry so they stay stable across the whole wait.
  assign resp_load = (state_q != StResp) && (state_d == StResp);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      pend_data_q <= 32'd0;
      pend_err_q  <= 1'b0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        pend_data_q <= acc_data;
        pend_err_q  <= acc_err;
      end
      if (resp_load) begin
        // With LATENCY==1 RESP is entered straight from the accept edge.
        rdata_q <= (state_q == StIdle) ? acc_data : pend_data_q;
        err_q   <= (state_q == StIdle) ? acc_err  : pend_err_q;
      end
    end
  end

  // Storage is deliberately not reset; a store commits on its accept edge.
  always_ff @(posedge clk_i) begin
    if (!rst_i && accept && req_write_i && !acc_err) begin
      mem[idx] <= req_wdata_i;
    end
  end

  assign req_ready_o  = (state_q == StIdle);
  assign busy_o       = (state_q != StIdle);
  assign resp_valid_o = (state_q == StResp);
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed table, reset corners, LATENCY=1
// instance, and randomized traffic against a word-level memory model.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned LAT   = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err, busy;
  logic [31:0] resp_rdata;

  logic        v1, rdy1, w1, rv1, e1, b1;
  logic [31:0] a1, d1, rd1;

  int npass  = 0;
  int ntotal = 0;

  logic [31:0] mm [int];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_rdata_o(resp_rdata), .resp_err_o(resp_err), .busy_o(busy)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(v1), .req_ready_o(rdy1), .req_write_i(w1),
    .req_addr_i(a1), .req_wdata_i(d1),
    .resp_valid_o(rv1), .resp_ready_i(1'b1),
    .resp_rdata_o(rd1), .resp_err_o(e1), .busy_o(b1)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          hold;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic logic ref_err(input logic [31:0] addr);
    return (addr % 4 != 0) || (addr >= DEPTH * 4);
  endfunction

  task automatic model_update(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    if (wr && !ref_err(addr)) mm[int'(addr / 4)] = wd;
  endtask

  // One full transaction on the LAT=3 instance; protocol timing checked inline.
  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input int hold, output logic [31:0] rd, output logic er);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("ready_wait_timeout", 32'(n < 50), 32'd1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    n = 1;
    while (!resp_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("latency", 32'(n), 32'(LAT));
    rd = resp_rdata;
    er = resp_err;
    for (int i = 0; i < hold; i++) begin
      if (i == 0) begin
        // Stray store while busy must be ignored.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0; req_wdata = 32'hBAD0BAD0;
      end
      @(posedge clk); #1;
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_rdata", resp_rdata, rd);
      chk("hold_err", 32'(resp_err), 32'(er));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("post_valid", 32'(resp_valid), 32'd0);
    chk("post_req_ready", 32'(req_ready), 32'd1);
    chk("post_rdata_held", resp_rdata, rd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[$];
    logic [31:0] rd;
    logic        er;

    vecs.push_back('{1'b1, 32'h10,  32'hDEADBEEF, 0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h10,  32'h0,        0, 1'b0, 32'hDEADBEEF});
    vecs.push_back('{1'b1, 32'h0,   32'h12345678, 0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h12,  32'h0,        0, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 32'h400, 32'h0,        0, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 32'h402, 32'hFFFFFFFF, 1, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 32'h3,   32'hFFFFFFFF, 0, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 32'h0,   32'h0,        0, 1'b0, 32'h12345678});
    vecs.push_back('{1'b0, 32'h10,  32'h0,        5, 1'b0, 32'hDEADBEEF});
    vecs.push_back('{1'b1, 32'h3FC, 32'hA5A5A5A5, 0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h3FC, 32'h0,        2, 1'b0, 32'hA5A5A5A5});
    vecs.push_back('{1'b0, 32'h0,   32'h0,        0, 1'b0, 32'h12345678});
    vecs.push_back('{1'b0, 32'hFFFFFFFC, 32'h0,   0, 1'b1, 32'h0});

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b0;
    v1 = 1'b0; w1 = 1'b0; a1 = '0; d1 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst1_req_ready", 32'(rdy1), 32'd1);

    // LATENCY=1 instance: store 1 @0 then load @0, response taken immediately.
    v1 = 1'b1; w1 = 1'b1; a1 = 32'h0; d1 = 32'h1;
    @(posedge clk); #1;
    chk("l1_st_valid", 32'(rv1), 32'd1);
    chk("l1_st_ready", 32'(rdy1), 32'd0);
    chk("l1_st_err", 32'(e1), 32'd0);
    w1 = 1'b0; d1 = 32'h0;
    @(posedge clk); #1;
    chk("l1_idle_valid", 32'(rv1), 32'd0);
    chk("l1_idle_ready", 32'(rdy1), 32'd1);
    @(posedge clk); #1;
    v1 = 1'b0;
    chk("l1_ld_valid", 32'(rv1), 32'd1);
    chk("l1_ld_rdata", rd1, 32'h1);
    @(posedge clk); #1;
    chk("l1_end_valid", 32'(rv1), 32'd0);
    chk("l1_end_busy", 32'(b1), 32'd0);

    foreach (vecs[i]) begin
      txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].hold, rd, er);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      model_update(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
    end

    // Reset while a store waits: store sticks, response is dropped.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("midrst_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_valid", 32'(resp_valid), 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rdata", resp_rdata, 32'd0);
    chk("midrst_err", 32'(resp_err), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_resp", 32'(resp_valid), 32'd0);
    end
    model_update(1'b1, 32'h20, 32'h55);
    txn(1'b0, 32'h20, 32'h0, 0, rd, er);
    chk("midrst_readback", rd, 32'h55);

    // Reset coinciding with a request: not accepted, nothing written.
    txn(1'b1, 32'h24, 32'h11, 0, rd, er);
    model_update(1'b1, 32'h24, 32'h11);
    rst = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h24; req_wdata = 32'h77;
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
    chk("rstreq_ready", 32'(req_ready), 32'd1);
    chk("rstreq_busy", 32'(busy), 32'd0);
    txn(1'b0, 32'h24, 32'h0, 0, rd, er);
    chk("rstreq_readback", rd, 32'h11);

    // Randomized traffic against the word-level model.
    for (int t = 0; t < 60; t++) begin
      logic [31:0] addr, wd, exp_rd;
      logic        wr, exp_err, known;
      int          r;
      r  = int'($urandom_range(0, 9));
      wr = 1'($urandom);
      wd = $urandom;
      if (r < 7)       addr = 32'($urandom_range(0, 15)) * 4;
      else if (r == 7) addr = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
      else if (r == 8) addr = DEPTH * 4 + 32'($urandom_range(0, 1000)) * 4;
      else             addr = DEPTH * 4 - 4;
      exp_err = ref_err(addr);
      known   = wr || exp_err || mm.exists(int'(addr / 4));
      exp_rd  = (wr || exp_err) ? 32'h0 : (known ? mm[int'(addr / 4)] : 32'h0);
      txn(wr, addr, wd, int'($urandom_range(0, 3)), rd, er);
      chk($sformatf("rnd%0d_err", t), 32'(er), 32'(exp_err));
      if (known) chk($sformatf("rnd%0d_rdata", t), rd, exp_rd);
      model_update(wr, addr, wd);
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
